// File: rtl/e203_exu_alu_rglr_pipe_pkg.sv
// Shared constants for the regular-ALU pipe: ALU info bus layout,
// strobe ordering and output FIFO entry layout.
package e203_exu_alu_rglr_pipe_pkg;

  // ALU decode-info bus layout (group, rv32 flag, then ALU fields)
  localparam int DECINFO_GRP_LSB    = 0;
  localparam int DECINFO_GRP_W      = 3;
  localparam int DECINFO_RV32       = 3;
  localparam int DECINFO_ALU_ADD    = 4;
  localparam int DECINFO_ALU_SUB    = 5;
  localparam int DECINFO_ALU_XOR    = 6;
  localparam int DECINFO_ALU_SLL    = 7;
  localparam int DECINFO_ALU_SRL    = 8;
  localparam int DECINFO_ALU_SRA    = 9;
  localparam int DECINFO_ALU_OR     = 10;
  localparam int DECINFO_ALU_AND    = 11;
  localparam int DECINFO_ALU_SLT    = 12;
  localparam int DECINFO_ALU_SLTU   = 13;
  localparam int DECINFO_ALU_LUI    = 14;
  localparam int DECINFO_ALU_OP2IMM = 15;
  localparam int DECINFO_ALU_OP1PC  = 16;
  localparam int DECINFO_ALU_NOP    = 17;
  localparam int DECINFO_ALU_ECAL   = 18;
  localparam int DECINFO_ALU_EBRK   = 19;
  localparam int DECINFO_ALU_WFI    = 20;
  localparam int DECINFO_ALU_WIDTH  = 21;

  // Datapath op strobes occupy a contiguous run of the info bus starting at ADD
  typedef enum logic [3:0] {
    STRB_ADD, STRB_SUB, STRB_XOR, STRB_SLL, STRB_SRL, STRB_SRA,
    STRB_OR, STRB_AND, STRB_SLT, STRB_SLTU, STRB_LUI
  } alu_strb_e;
  localparam int ALU_STRB_NUM = 11;

  // FIFO entry: {res, ecall, ebreak, wfi, itag}, itag in the LSBs
  function automatic int ent_w(input int xlen, input int itag_w);
    return xlen + 3 + itag_w;
  endfunction

  localparam int XLEN_DEF   = 32;
  localparam int ITAG_W_DEF = 2;
  localparam int ENT_W      = ent_w(XLEN_DEF, ITAG_W_DEF);

endpackage

// File: rtl/e203_exu_alu_rglr_fifo.sv
// Generic DEPTH x W valid/ready FIFO with synchronous flush and occupancy
// count. The head is read combinationally so an entry written in one cycle
// is visible at the output in the next; the head reads as zero when empty.
module e203_exu_alu_rglr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_wr_valid,
  output logic         o_wr_ready,
  input  logic [W-1:0] i_wr_data,
  output logic         o_rd_valid,
  input  logic         i_rd_ready,
  output logic [W-1:0] o_rd_data,
  output logic [2:0]   o_cnt
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       CNT_FULL = 3'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_cnt;
  logic [W-1:0]     r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  // Wrap by explicit compare so non-power-of-two depths cycle correctly
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == 3'd0);
  assign w_wr       = i_wr_valid & ~w_full & ~i_flush;
  assign w_rd       = ~w_empty & i_rd_ready & ~i_flush;
  assign o_wr_ready = ~w_full;
  assign o_rd_valid = ~w_empty;
  assign o_cnt      = r_cnt;
  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  // Control state: pointers and count; flush overrides any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 3'd0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 3'd0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_cnt <= r_cnt + {2'b00, w_wr} - {2'b00, w_rd};
    end
  end

  // Storage: one write-enabled register per entry, no reset needed
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (w_wr && (r_wr_ptr == PTR_W'(gi))) r_mem[gi] <= i_wr_data;
    end
  end

endmodule

// File: rtl/e203_exu_alu_rglr_pipe.sv
// Regular-ALU issue/commit wrapper: decodes the ALU info bus into shared
// datapath strobes, muxes operands, and buffers result plus commit flags in
// a small output FIFO so commit backpressure never reaches issue directly.
module e203_exu_alu_rglr_pipe
  import e203_exu_alu_rglr_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int INFO_W  = DECINFO_ALU_WIDTH,
  parameter int ITAG_W  = 2,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_i_valid,
  output logic              alu_i_ready,
  input  logic [XLEN-1:0]   alu_i_rs1,
  input  logic [XLEN-1:0]   alu_i_rs2,
  input  logic [XLEN-1:0]   alu_i_imm,
  input  logic [PC_SIZE-1:0] alu_i_pc,
  input  logic [INFO_W-1:0] alu_i_info,
  input  logic [ITAG_W-1:0] alu_i_itag,
  input  logic              alu_i_flush,
  output logic              alu_o_valid,
  input  logic              alu_o_ready,
  output logic [XLEN-1:0]   alu_o_wbck_wdat,
  output logic              alu_o_wbck_err,
  output logic              alu_o_cmt_ecall,
  output logic              alu_o_cmt_ebreak,
  output logic              alu_o_cmt_wfi,
  output logic [ITAG_W-1:0] alu_o_itag,
  output logic [2:0]        alu_o_cnt,
  output logic              alu_req_alu_add,
  output logic              alu_req_alu_sub,
  output logic              alu_req_alu_xor,
  output logic              alu_req_alu_sll,
  output logic              alu_req_alu_srl,
  output logic              alu_req_alu_sra,
  output logic              alu_req_alu_or,
  output logic              alu_req_alu_and,
  output logic              alu_req_alu_slt,
  output logic              alu_req_alu_sltu,
  output logic              alu_req_alu_lui,
  output logic [XLEN-1:0]   alu_req_alu_op1,
  output logic [XLEN-1:0]   alu_req_alu_op2,
  input  logic [XLEN-1:0]   alu_req_alu_res
);

  localparam int EW       = ent_w(XLEN, ITAG_W);
  localparam int E_WFI    = ITAG_W;
  localparam int E_EBRK   = ITAG_W + 1;
  localparam int E_ECAL   = ITAG_W + 2;
  localparam int E_RES    = ITAG_W + 3;

  logic                    w_fifo_wr_ready;
  logic                    w_enq;
  logic [ALU_STRB_NUM-1:0] w_strb;
  logic [XLEN-1:0]         w_pc_ext;
  logic [EW-1:0]           w_wr_data;
  logic [EW-1:0]           w_head;
  logic                    w_unused_info;

  // Flush blocks issue outright; ready never depends on alu_o_ready
  assign alu_i_ready = w_fifo_wr_ready & ~alu_i_flush;
  assign w_enq       = alu_i_valid & alu_i_ready;

  // Operand muxes are left ungated; only the strobes qualify the request
  assign w_pc_ext        = XLEN'(alu_i_pc);
  assign alu_req_alu_op1 = alu_i_info[DECINFO_ALU_OP1PC]  ? w_pc_ext  : alu_i_rs1;
  assign alu_req_alu_op2 = alu_i_info[DECINFO_ALU_OP2IMM] ? alu_i_imm : alu_i_rs2;

  // Strobe gating: every op qualified by enq, ADD additionally suppressed by NOP
  for (genvar gi = 0; gi < ALU_STRB_NUM; gi++) begin : g_strb
    if (gi == int'(STRB_ADD)) begin : g_add
      assign w_strb[gi] = alu_i_info[DECINFO_ALU_ADD + gi] & ~alu_i_info[DECINFO_ALU_NOP] & w_enq;
    end else begin : g_op
      assign w_strb[gi] = alu_i_info[DECINFO_ALU_ADD + gi] & w_enq;
    end
  end

  assign alu_req_alu_add  = w_strb[STRB_ADD];
  assign alu_req_alu_sub  = w_strb[STRB_SUB];
  assign alu_req_alu_xor  = w_strb[STRB_XOR];
  assign alu_req_alu_sll  = w_strb[STRB_SLL];
  assign alu_req_alu_srl  = w_strb[STRB_SRL];
  assign alu_req_alu_sra  = w_strb[STRB_SRA];
  assign alu_req_alu_or   = w_strb[STRB_OR];
  assign alu_req_alu_and  = w_strb[STRB_AND];
  assign alu_req_alu_slt  = w_strb[STRB_SLT];
  assign alu_req_alu_sltu = w_strb[STRB_SLTU];
  assign alu_req_alu_lui  = w_strb[STRB_LUI];

  // Group and rv32 fields carry no meaning inside the ALU wrapper
  assign w_unused_info = ^alu_i_info[DECINFO_RV32:DECINFO_GRP_LSB];

  assign w_wr_data = {alu_req_alu_res,
                      alu_i_info[DECINFO_ALU_ECAL],
                      alu_i_info[DECINFO_ALU_EBRK],
                      alu_i_info[DECINFO_ALU_WFI],
                      alu_i_itag};

  e203_exu_alu_rglr_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (alu_i_flush),
    .i_wr_valid (w_enq),
    .o_wr_ready (w_fifo_wr_ready),
    .i_wr_data  (w_wr_data),
    .o_rd_valid (alu_o_valid),
    .i_rd_ready (alu_o_ready),
    .o_rd_data  (w_head),
    .o_cnt      (alu_o_cnt)
  );

  // Head entry unpack; the FIFO already zeroes it when empty
  assign alu_o_wbck_wdat  = w_head[E_RES +: XLEN];
  assign alu_o_cmt_ecall  = w_head[E_ECAL];
  assign alu_o_cmt_ebreak = w_head[E_EBRK];
  assign alu_o_cmt_wfi    = w_head[E_WFI];
  assign alu_o_itag       = w_head[ITAG_W-1:0];
  assign alu_o_wbck_err   = alu_o_cmt_ecall | alu_o_cmt_ebreak | alu_o_cmt_wfi;

endmodule

// File: tb/tb_e203_exu_alu_rglr_pipe.sv
module tb_e203_exu_alu_rglr_pipe;

  localparam int XLEN    = 32;
  localparam int PC_SIZE = 32;
  localparam int INFO_W  = 21;
  localparam int ITAG_W  = 2;
  localparam int DEPTH   = 3;

  typedef enum int {
    K_ADD = 0, K_SUB, K_XOR, K_SLL, K_SRL, K_SRA, K_OR, K_AND,
    K_SLT, K_SLTU, K_LUI, K_NOP, K_ECALL, K_EBREAK, K_WFI
  } kind_e;

  typedef struct {
    logic [31:0] res;
    logic        ecall;
    logic        ebreak;
    logic        wfi;
    logic [1:0]  itag;
  } ent_t;

  typedef struct {
    kind_e       kind;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        op2imm;
    logic        op1pc;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              i_ready;
  logic [XLEN-1:0]   rs1, rs2, imm;
  logic [PC_SIZE-1:0] pc;
  logic [INFO_W-1:0] info;
  logic [ITAG_W-1:0] itag;
  logic              flush;
  logic              o_valid;
  logic              o_ready;
  logic [XLEN-1:0]   wdat;
  logic              err, ecall, ebreak, wfi;
  logic [ITAG_W-1:0] o_itag;
  logic [2:0]        cnt;
  logic s_add, s_sub, s_xor, s_sll, s_srl, s_sra, s_or, s_and, s_slt, s_sltu, s_lui;
  logic [XLEN-1:0]   op1, op2, dp_res;
  logic [10:0]       dut_strb;

  int    checks;
  int    errors;
  ent_t  q[$];
  logic  exp_enq;
  kind_e cur_kind;
  logic  cur_op2imm, cur_op1pc;
  vec_t  tbl[16];

  e203_exu_alu_rglr_pipe #(
    .XLEN(XLEN), .PC_SIZE(PC_SIZE), .INFO_W(INFO_W), .ITAG_W(ITAG_W), .DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(i_valid), .alu_i_ready(i_ready),
    .alu_i_rs1(rs1), .alu_i_rs2(rs2), .alu_i_imm(imm), .alu_i_pc(pc),
    .alu_i_info(info), .alu_i_itag(itag), .alu_i_flush(flush),
    .alu_o_valid(o_valid), .alu_o_ready(o_ready),
    .alu_o_wbck_wdat(wdat), .alu_o_wbck_err(err),
    .alu_o_cmt_ecall(ecall), .alu_o_cmt_ebreak(ebreak), .alu_o_cmt_wfi(wfi),
    .alu_o_itag(o_itag), .alu_o_cnt(cnt),
    .alu_req_alu_add(s_add), .alu_req_alu_sub(s_sub), .alu_req_alu_xor(s_xor),
    .alu_req_alu_sll(s_sll), .alu_req_alu_srl(s_srl), .alu_req_alu_sra(s_sra),
    .alu_req_alu_or(s_or), .alu_req_alu_and(s_and), .alu_req_alu_slt(s_slt),
    .alu_req_alu_sltu(s_sltu), .alu_req_alu_lui(s_lui),
    .alu_req_alu_op1(op1), .alu_req_alu_op2(op2), .alu_req_alu_res(dp_res)
  );

  assign dut_strb = {s_lui, s_sltu, s_slt, s_and, s_or, s_sra, s_srl, s_sll, s_xor, s_sub, s_add};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in shared ALU datapath: result is 0 when no strobe is raised
  always_comb begin
    dp_res = '0;
    if (s_add)       dp_res = op1 + op2;
    else if (s_sub)  dp_res = op1 - op2;
    else if (s_xor)  dp_res = op1 ^ op2;
    else if (s_sll)  dp_res = op1 << op2[4:0];
    else if (s_srl)  dp_res = op1 >> op2[4:0];
    else if (s_sra)  dp_res = 32'($signed(op1) >>> op2[4:0]);
    else if (s_or)   dp_res = op1 | op2;
    else if (s_and)  dp_res = op1 & op2;
    else if (s_slt)  dp_res = {31'd0, $signed(op1) < $signed(op2)};
    else if (s_sltu) dp_res = {31'd0, op1 < op2};
    else if (s_lui)  dp_res = op2;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [INFO_W-1:0] mk_info(input kind_e k, input logic o2i, input logic o1p);
    logic [INFO_W-1:0] v;
    v = '0;
    v[3] = 1'b1;
    if (k <= K_LUI) v[4 + int'(k)] = 1'b1;
    else if (k == K_NOP) begin v[4] = 1'b1; v[17] = 1'b1; end
    else if (k == K_ECALL) v[18] = 1'b1;
    else if (k == K_EBREAK) v[19] = 1'b1;
    else v[20] = 1'b1;
    v[15] = o2i;
    v[16] = o1p;
    return v;
  endfunction

  // Reference result from the instruction kind and selected operands
  function automatic logic [31:0] model_res(input kind_e k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      K_ADD:   return a + b;
      K_SUB:   return a - b;
      K_XOR:   return a ^ b;
      K_SLL:   return a << b[4:0];
      K_SRL:   return a >> b[4:0];
      K_SRA:   return 32'($signed(a) >>> b[4:0]);
      K_OR:    return a | b;
      K_AND:   return a & b;
      K_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      K_LUI:   return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic v, input kind_e k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic o2i, input logic o1p,
                       input logic [1:0] tg, input logic fl, input logic ordy);
    i_valid = v; cur_kind = k; rs1 = a; rs2 = b; imm = im; pc = p;
    cur_op2imm = o2i; cur_op1pc = o1p; info = mk_info(k, o2i, o1p);
    itag = tg; flush = fl; o_ready = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, K_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, ordy);
  endtask

  task automatic check_outputs();
    logic        exp_ready;
    logic [10:0] exp_s;
    logic [31:0] a, b;
    ent_t        h;
    exp_ready = (q.size() < DEPTH) && !flush;
    exp_enq   = i_valid && exp_ready;
    chk("i_ready", 32'(i_ready), 32'(exp_ready));
    chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
    chk("cnt", 32'(cnt), 32'(q.size()));
    h = '{res: 32'd0, ecall: 1'b0, ebreak: 1'b0, wfi: 1'b0, itag: 2'd0};
    if (q.size() != 0) h = q[0];
    chk("wdat", wdat, h.res);
    chk("ecall", 32'(ecall), 32'(h.ecall));
    chk("ebreak", 32'(ebreak), 32'(h.ebreak));
    chk("wfi", 32'(wfi), 32'(h.wfi));
    chk("err", 32'(err), 32'(h.ecall | h.ebreak | h.wfi));
    chk("itag", 32'(o_itag), 32'(h.itag));
    exp_s = '0;
    if (exp_enq && cur_kind <= K_LUI) exp_s[int'(cur_kind)] = 1'b1;
    chk("strobes", 32'(dut_strb), 32'(exp_s));
    a = cur_op1pc ? pc : rs1;
    b = cur_op2imm ? imm : rs2;
    chk("op1", op1, a);
    chk("op2", op2, b);
  endtask

  task automatic update_model();
    logic [31:0] a, b;
    ent_t e;
    a = cur_op1pc ? pc : rs1;
    b = cur_op2imm ? imm : rs2;
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && o_ready) q.delete(0);
      if (exp_enq) begin
        e = '{res: model_res(cur_kind, a, b), ecall: (cur_kind == K_ECALL),
              ebreak: (cur_kind == K_EBREAK), wfi: (cur_kind == K_WFI), itag: itag};
        q.push_back(e);
      end
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic finish_cycle();
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle(1'b1);

    tbl[0]  = '{K_ADD,   32'd5,          32'd7,   32'd0,          32'd0,     1'b0, 1'b0, 32'd12,         1'b0};
    tbl[1]  = '{K_SUB,   32'd5,          32'd7,   32'd0,          32'd0,     1'b0, 1'b0, 32'hFFFFFFFE,   1'b0};
    tbl[2]  = '{K_XOR,   32'h0000F0F0,   32'h0FF0, 32'd0,         32'd0,     1'b0, 1'b0, 32'h0000FF00,   1'b0};
    tbl[3]  = '{K_SLL,   32'd1,          32'd99,  32'd4,          32'd0,     1'b1, 1'b0, 32'd16,         1'b0};
    tbl[4]  = '{K_SRL,   32'h80000000,   32'd31,  32'd0,          32'd0,     1'b0, 1'b0, 32'd1,          1'b0};
    tbl[5]  = '{K_SRA,   32'h80000000,   32'd0,   32'd4,          32'd0,     1'b1, 1'b0, 32'hF8000000,   1'b0};
    tbl[6]  = '{K_OR,    32'h0000000F,   32'hF0,  32'd0,          32'd0,     1'b0, 1'b0, 32'h000000FF,   1'b0};
    tbl[7]  = '{K_AND,   32'h000000FF,   32'h0F,  32'd0,          32'd0,     1'b0, 1'b0, 32'h0000000F,   1'b0};
    tbl[8]  = '{K_SLT,   32'hFFFFFFFF,   32'd1,   32'd0,          32'd0,     1'b0, 1'b0, 32'd1,          1'b0};
    tbl[9]  = '{K_SLTU,  32'hFFFFFFFF,   32'd1,   32'd0,          32'd0,     1'b0, 1'b0, 32'd0,          1'b0};
    tbl[10] = '{K_LUI,   32'd0,          32'd0,   32'h12345000,   32'd0,     1'b1, 1'b0, 32'h12345000,   1'b0};
    tbl[11] = '{K_ADD,   32'd77,         32'd0,   32'd8,          32'h100,   1'b1, 1'b1, 32'h00000108,   1'b0};
    tbl[12] = '{K_ECALL, 32'd1,          32'd2,   32'd0,          32'd0,     1'b0, 1'b0, 32'd0,          1'b1};
    tbl[13] = '{K_EBREAK,32'd1,          32'd2,   32'd0,          32'd0,     1'b0, 1'b0, 32'd0,          1'b1};
    tbl[14] = '{K_WFI,   32'd1,          32'd2,   32'd0,          32'd0,     1'b0, 1'b0, 32'd0,          1'b1};
    tbl[15] = '{K_NOP,   32'd3,          32'd4,   32'd0,          32'd0,     1'b0, 1'b0, 32'd0,          1'b0};

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    settle();
    finish_cycle();
    rst_n = 1'b1;

    // Single-op vectors with free-running commit
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tbl[i].kind, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].pc,
            tbl[i].op2imm, tbl[i].op1pc, 2'(i), 1'b0, 1'b1);
      settle();
      finish_cycle();
      idle(1'b1);
      settle();
      chk("tbl_wdat", wdat, tbl[i].exp_res);
      chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
      chk("tbl_valid", 32'(o_valid), 32'd1);
      $display("vec %0d kind=%0d wdat=%0h err=%0b", i, int'(tbl[i].kind), wdat, err);
      finish_cycle();
    end

    // Fill to capacity with commit stalled, then one extra issue must block
    for (int j = 0; j < DEPTH; j++) begin
      drive(1'b1, K_ADD, 32'(j), 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 2'(j), 1'b0, 1'b0);
      settle();
      finish_cycle();
    end
    drive(1'b1, K_SUB, 32'd50, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    settle();
    chk("full_ready", 32'(i_ready), 32'd0);
    chk("full_cnt", 32'(cnt), 32'(DEPTH));
    chk("full_nostrb", 32'(s_sub), 32'd0);
    finish_cycle();
    o_ready = 1'b1;
    begin
      bit accepted;
      accepted = 1'b0;
      for (int c = 0; c < 6 && !accepted; c++) begin
        settle();
        check_outputs();
        accepted = exp_enq;
        update_model();
        @(posedge clk);
        #1;
        if (accepted) idle(1'b1);
      end
      chk("blocked_op_accepted", 32'(accepted), 32'd1);
    end
    idle(1'b1);
    repeat (DEPTH + 2) begin
      settle();
      finish_cycle();
    end

    // Flush with two buffered entries, concurrent issue and commit handshake
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, K_XOR, 32'h55, 32'(j), 32'd0, 32'd0, 1'b0, 1'b0, 2'(j), 1'b0, 1'b0);
      settle();
      finish_cycle();
    end
    drive(1'b1, K_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1);
    settle();
    chk("flush_add_strb", 32'(s_add), 32'd0);
    chk("flush_ready", 32'(i_ready), 32'd0);
    finish_cycle();
    idle(1'b1);
    settle();
    chk("post_flush_cnt", 32'(cnt), 32'd0);
    chk("post_flush_valid", 32'(o_valid), 32'd0);
    finish_cycle();

    // Random issue against toggling commit readiness and rare flushes
    for (int c = 0; c < 60; c++) begin
      drive(($urandom_range(0, 3) != 0), kind_e'($urandom_range(0, 14)), $urandom, $urandom,
            $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0), 1'(c % 2 == 0));
      settle();
      finish_cycle();
    end
    idle(1'b1);
    repeat (DEPTH + 1) begin
      settle();
      finish_cycle();
    end

    // Asynchronous reset with two entries buffered
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, K_OR, 32'h10, 32'(j), 32'd0, 32'd0, 1'b0, 1'b0, 2'(j), 1'b0, 1'b0);
      settle();
      finish_cycle();
    end
    idle(1'b0);
    #2;
    chk("pre_rst_cnt", 32'(cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(o_valid), 32'd0);
    chk("async_cnt", 32'(cnt), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b1);
    settle();
    chk("rst_release_ready", 32'(i_ready), 32'd1);
    finish_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_exu_alu_rglr_pipe.md
Name: e203_exu_alu_rglr_pipe

Overview:
- Parametrised successor of the regular-ALU issue/commit wrapper in the E203 EXU.
- Decodes the ALU info bus into shared-datapath requests and selects op1/op2 (pc/rs1, imm/rs2).
- Captures the shared-datapath result, commit flags and an instruction tag into a DEPTH-entry output FIFO, so the commit stage is decoupled from issue by registered, backpressurable storage.
- Adds a synchronous flush that the previous generation did not have.

Parameters:
- XLEN, 32, datapath width.
- PC_SIZE, 32, PC width; zero-extended to XLEN when PC_SIZE < XLEN.
- INFO_W, `E203_DECINFO_ALU_WIDTH, width of the ALU info bus.
- ITAG_W, 2, instruction tag width.
- DEPTH, 2, output FIFO entries; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_i_valid  in  1  issue valid
- alu_i_ready  out  1  issue ready
- alu_i_rs1  in  XLEN  source operand 1
- alu_i_rs2  in  XLEN  source operand 2
- alu_i_imm  in  XLEN  immediate
- alu_i_pc  in  PC_SIZE  instruction PC
- alu_i_info  in  INFO_W  decoded ALU info
- alu_i_itag  in  ITAG_W  instruction tag
- alu_i_flush  in  1  discard all buffered entries
- alu_o_valid  out  1  commit valid
- alu_o_ready  in  1  commit ready
- alu_o_wbck_wdat  out  XLEN  write-back data
- alu_o_wbck_err  out  1  ecall | ebreak | wfi
- alu_o_cmt_ecall  out  1  commit flag
- alu_o_cmt_ebreak  out  1  commit flag
- alu_o_cmt_wfi  out  1  commit flag
- alu_o_itag  out  ITAG_W  tag of head entry
- alu_o_cnt  out  3  occupied entries
- alu_req_alu_{add,sub,xor,sll,srl,sra,or,and,slt,sltu,lui}  out  1 each  datapath op strobes
- alu_req_alu_op1  out  XLEN  operand 1
- alu_req_alu_op2  out  XLEN  operand 2
- alu_req_alu_res  in  XLEN  datapath result, combinational from op1/op2/strobes

Behaviour:
- Operand select:
  - op1 = OP1PC ? zext(pc) : rs1.
  - op2 = OP2IMM ? imm : rs2.
  - Both are ungated.
- Strobe gating:
  - Every strobe is ANDed with enq = alu_i_valid & alu_i_ready & ~alu_i_flush.
  - add is additionally masked by ~NOP.
  - Idle or blocked cycles drive all strobes to 0.
- alu_i_ready = ~full & ~alu_i_flush. No combinational path from alu_o_ready.
- Enqueue:
  - On enq, write {res, ecall, ebreak, wfi, itag} at wr_ptr and advance wr_ptr modulo DEPTH.
  - A NOP still enqueues, with res as driven by the datapath.
- Dequeue:
  - deq = alu_o_valid & alu_o_ready; advance rd_ptr modulo DEPTH.
- Latency: issue to alu_o_valid is 1 cycle when the FIFO is empty.
- Simultaneous enq and deq: count unchanged, both pointers advance. Allowed at any non-full occupancy; at full, enq is impossible.
- Outputs:
  - alu_o_valid = (cnt != 0).
  - Data and flag outputs show the head entry, forced to 0 when empty.
  - alu_o_wbck_err = OR of the head's three flags.
- Flush: next cycle cnt = 0 and both pointers = 0. Flush wins over a same-cycle enq and deq; the deq handshake is ignored (entry discarded, not committed).
- Reset: asynchronous. Pointers, count and all entry valid state clear to 0; alu_i_ready = 1 and every other output = 0 after reset. Asserting reset mid-transfer drops all entries.
- Pointer wrap: handled with explicit compare for non-power-of-two DEPTH (3). cnt saturates at DEPTH by construction.
- Storage needs no reset; only control state is reset.

Decomposition:
- Shared defines: DECINFO_ALU_* bit indices and widths, already in e203_defines.v.
- Package localparams: entry layout, ENT_W = XLEN + 3 + ITAG_W.
- One natural sub-module: e203_exu_alu_rglr_fifo, a generic DEPTH x ENT_W valid/ready FIFO with flush and count output. The top holds only decode, operand muxing and strobe gating.

Test Plan:
- Reset, then ADD rs1=5, rs2=7, alu_o_ready=1 -> strobe add=1 in the issue cycle; next cycle alu_o_valid=1, wdat=12, cnt=1; following cycle cnt=0.
- DEPTH=2, alu_o_ready=0, issue 3 back-to-back ops -> first two accepted, alu_i_ready=0 on the third, cnt=2. Release ready -> results drain in order with itags 0,1, then the third is accepted.
- ECALL (info ECAL=1) -> head ecall=1, wbck_err=1. WFI -> wfi=1, err=1. NOP (ADD|NOP) -> add strobe 0, still enqueued.
- FIFO holding 2 entries, flush asserted together with valid issue and alu_o_ready=1 -> next cycle cnt=0, alu_o_valid=0, no entry committed, add strobe 0.
- DEPTH=3, continuous issue with alu_o_ready toggling 1/0 over 20 ops -> scoreboard matches order and tags, pointers wrap correctly, cnt never exceeds 3.
- Reset pulsed low mid-stream with cnt=2 -> alu_o_valid drops immediately (async), alu_i_ready=1 after release, cnt=0.
